sha1_padder: RTL and testbench

SHA1_PADDER -- requirements
Module: sha1_padder

---
 rtl/sha1_padder.sv | 168 ++++++++++++++++
 tb/tb_sha1_padder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_padder.sv
// sha1_padder: byte-stream to 512-bit SHA-1 block padder.
// Collects message bytes into 64-byte blocks, then appends 0x80, zero fill and
// the 64-bit big-endian bit length, spilling into an extra block when needed.
// Optional feature: define SHA1_PADDER_BYTECNT_EN to expose byte_count[63:0].
module sha1_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         msg_end,
  output logic         in_ready,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  output logic         blk_last,
  input  logic         blk_ready
`ifdef SHA1_PADDER_BYTECNT_EN
  ,
  output logic [63:0]  byte_count
`endif
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2,
    PAD2 = 2'd3
  } state_e;

  state_e           state_q, state_d;
  // Element 0 is the most significant byte, so the packed buffer maps
  // directly onto blk_data with byte 0 in [511:504].
  logic [0:63][7:0] buf_q, buf_d;
  logic [6:0]       n_q, n_d;
  logic [63:0]      cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic             byte_acc;
  logic             xfer;
  logic [63:0]      bit_len;
  logic [0:63][7:0] pad_bytes;
  logic [511:0]     blk_flat;

  assign in_ready  = (state_q == FILL) && !rst;
  assign blk_valid = (state_q != FILL);
  assign byte_acc  = in_valid && in_ready;
  assign xfer      = blk_valid && blk_ready;
  assign bit_len   = {cnt_q[60:0], 3'b000};

`ifdef SHA1_PADDER_BYTECNT_EN
  assign byte_count = cnt_q;
`endif

  // State register and datapath flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: byte capture in FILL, block hand-off on transfer.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      FILL: begin
        if (byte_acc) begin
          buf_d[n_q[5:0]] = in_data;
          n_d             = n_q + 7'd1;
          cnt_d           = cnt_q + 64'd1;
          // A full block must go out before end-of-message can be padded,
          // so a simultaneous msg_end is remembered rather than acted on.
          if (n_q == 7'd63) begin
            state_d = EMIT;
            pend_d  = msg_end;
          end else if (msg_end) begin
            state_d = PAD;
          end
        end else if (msg_end && in_ready) begin
          state_d = PAD;
        end
      end
      EMIT: begin
        if (xfer) begin
          n_d     = '0;
          state_d = pend_q ? PAD : FILL;
        end
      end
      PAD: begin
        if (xfer) begin
          if (n_q >= 7'd56) begin
            state_d = PAD2;
          end else begin
            state_d = FILL;
            n_d     = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
      end
      PAD2: begin
        if (xfer) begin
          state_d = FILL;
          n_d     = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Padded view of the buffer: valid bytes, 0x80 marker, then zeros.
  // Stale bytes past n from an earlier block are masked here.
  always_comb begin
    pad_bytes = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (7'(i) < n_q) begin
        pad_bytes[i] = buf_q[i];
      end else if (7'(i) == n_q) begin
        pad_bytes[i] = 8'h80;
      end else begin
        pad_bytes[i] = 8'h00;
      end
    end
  end

  // Block output mux; all sources are flops, so the output holds while stalled.
  always_comb begin
    blk_flat = '0;
    blk_last = 1'b0;
    case (state_q)
      EMIT: begin
        blk_flat = buf_q;
      end
      PAD: begin
        blk_flat = pad_bytes;
        if (n_q < 7'd56) begin
          blk_flat[63:0] = bit_len;
          blk_last       = 1'b1;
        end
      end
      PAD2: begin
        blk_flat[63:0] = bit_len;
        blk_last       = 1'b1;
      end
      default: begin
        blk_flat = '0;
        blk_last = 1'b0;
      end
    endcase
  end

  assign blk_data = blk_flat;

endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: randomized scoreboard bench for sha1_padder.
// Expected blocks come from a message-level padding model; a monitor process
// compares every block transfer and checks hold stability under backpressure.
module tb_sha1_padder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         msg_end;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_ready;
`ifdef SHA1_PADDER_BYTECNT_EN
  logic [63:0]  byte_count;
`endif

  sha1_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .msg_end   (msg_end),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
`ifdef SHA1_PADDER_BYTECNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  blk_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hold_req = 0;
  bit   timed_out = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pad the whole message as a byte list, then slice into blocks.
  function automatic void push_expected(input bq_t msg);
    bq_t         p;
    logic [63:0] len;
    blk_t        b;
    int          nblk;
    p   = msg;
    len = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      b.data = '0;
      for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = p[bi*64+i];
      b.last = (bi == nblk - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Monitor: drives blk_ready, compares each transfer, checks stall stability.
  initial begin
    logic [511:0] held_data;
    logic         held_last;
    bit           holding;
    blk_t         e;
    holding   = 0;
    held_data = '0;
    held_last = 1'b0;
    blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding   = 0;
        blk_ready = 1'b0;
      end else begin
        if (holding) begin
          check("hold_valid", blk_valid, 1);
          check("hold_data", blk_data, held_data);
          check("hold_last", blk_last, held_last);
        end
        holding = 0;
        if (blk_valid) begin
          check("in_ready_low_while_blk", in_ready, 0);
          if (hold_req > 0) begin
            blk_ready = 1'b0;
            hold_req--;
          end else begin
            blk_ready = ($urandom_range(0, 3) != 0);
          end
          if (blk_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_block: got %h expected no block", blk_data);
            end else begin
              e = exp_q.pop_front();
              check("blk_data", blk_data, e.data);
              check("blk_last", blk_last, e.last);
            end
          end else begin
            holding   = 1;
            held_data = blk_data;
            held_last = blk_last;
          end
        end else begin
          blk_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Offer one item when in_ready; while not ready, sometimes drive junk that must be ignored.
  task automatic drive_item(input logic [7:0] d, input logic v, input logic e);
    int waited;
    bit done;
    waited = 0;
    done   = 0;
    while (!done && !timed_out) begin
      @(negedge clk);
      if (in_ready && ($urandom_range(0, 4) != 0)) begin
        in_valid = v;
        in_data  = d;
        msg_end  = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        msg_end  = 1'b0;
        in_data  = 8'($urandom);
        done     = 1;
      end else begin
        if (!in_ready && ($urandom_range(0, 1) != 0)) begin
          in_valid = 1'b1;
          in_data  = 8'($urandom);
          msg_end  = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
          msg_end  = 1'b0;
        end
        waited++;
        if (waited > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", waited);
          timed_out = 1;
          in_valid  = 1'b0;
          msg_end   = 1'b0;
        end
      end
    end
  endtask

  task automatic send_bytes(input bq_t msg, input int count);
    for (int i = 0; i < count; i++) drive_item(msg[i], 1'b1, 1'b0);
  endtask

  task automatic send_msg(input bq_t msg, input bit combine);
    push_expected(msg);
    for (int i = 0; i < msg.size(); i++)
      drive_item(msg[i], 1'b1, combine && (i == msg.size() - 1));
    if (!combine || msg.size() == 0) drive_item(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic bq_t fill_bytes(input int len, input logic [7:0] v, input bit rnd);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(rnd ? 8'($urandom) : v);
    return q;
  endfunction

  initial begin
    bq_t abc;
    bq_t m;
    abc = '{8'h61, 8'h62, 8'h63};
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    msg_end  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_blk_data", blk_data, '0);
`ifdef SHA1_PADDER_BYTECNT_EN
    check("rst_byte_count", byte_count, '0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    send_msg(abc, 1'b0);
    send_msg(fill_bytes(0, 8'h00, 1'b0), 1'b0);
    send_msg(fill_bytes(55, 8'h41, 1'b0), 1'b1);
    send_msg(fill_bytes(56, 8'h41, 1'b0), 1'b0);
    send_msg(fill_bytes(64, 8'h00, 1'b1), 1'b1);
    send_msg(fill_bytes(64, 8'h00, 1'b1), 1'b0);
    wait_drain();
`ifdef SHA1_PADDER_BYTECNT_EN
    check("byte_count_cleared", byte_count, '0);
`endif

    hold_req = 5;
    send_msg(abc, 1'b1);
    wait_drain();

    m = fill_bytes(30, 8'h00, 1'b1);
    send_bytes(m, 30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_blk_valid", blk_valid, 0);
    check("midrst_blk_data", blk_data, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_midrst", in_ready, 1);
    send_msg(abc, 1'b1);
    wait_drain();

    for (int r = 0; r < 12; r++) begin
      send_msg(fill_bytes($urandom_range(0, 150), 8'h00, 1'b1), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    check("scoreboard_empty", 512'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
